// File: rtl/sd_cmd.sv
// sd_cmd: SD CMD-line engine in the card clock domain.
// Sends a CRC7-protected command frame, then captures and checks the response.
module sd_cmd #(
    parameter int NCR_MAX = 64,
    parameter int NRC_GAP = 8
) (
    input  logic        iclk,
    input  logic        irst_n,
    input  logic        istart,
    input  logic [5:0]  iindex,
    input  logic [31:0] iarg,
    input  logic        icmd,
    output logic        ocmd,
    output logic        ocmd_oe,
    output logic        odone,
    output logic [75:0] oresp,
    output logic        otimeout,
    output logic        ocrc_err,
    output logic        obusy
);
    localparam int TW = $clog2(NCR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT, S_RECV, S_GAP, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        RT_NONE, RT_R48, RT_R2, RT_R3
    } rtype_t;

    state_t          r_state;
    rtype_t          r_rtype;
    logic [7:0]      r_bitcnt;
    logic [TW-1:0]   r_tocnt;
    logic [46:0]     r_txsh;
    logic [82:0]     r_rx;
    logic [6:0]      r_crc;

    logic [47:0]     w_frame;
    logic [83:0]     w_rx;
    logic [7:0]      w_idx;
    logic            w_crc_on;
    logic            w_err;

    function automatic logic [6:0] crc7_step(
        input logic [6:0] c,
        input logic       b
    );
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [47:0] cmd_frame(
        input logic [5:0]  idx,
        input logic [31:0] arg
    );
        logic [39:0] h;
        logic [6:0]  c;
        h = {2'b01, idx, arg};
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, h[i]);
        end
        return {h, c, 1'b1};
    endfunction

    function automatic rtype_t decode(input logic [5:0] idx);
        case (idx)
            6'd0, 6'd15: decode = RT_NONE;
            6'd2, 6'd9:  decode = RT_R2;
            6'd41:       decode = RT_R3;
            default:     decode = RT_R48;
        endcase
    endfunction

    // Received bits are indexed by their frame position; the start bit
    // is consumed in WAIT, so the newest bit in RECV is frame bit r_bitcnt-1.
    assign w_frame  = cmd_frame(iindex, iarg);
    assign w_rx     = {r_rx, icmd};
    assign w_idx    = r_bitcnt - 8'd1;
    assign w_crc_on = (w_idx >= 8'd8) &&
                      ((r_rtype != RT_R2) || (w_idx <= 8'd127));
    assign w_err    = ~w_rx[0] |
                      ((r_rtype != RT_R3) && (r_crc != w_rx[7:1])) |
                      ((r_rtype != RT_R2) && w_rx[46]);

    // Transaction FSM with all outputs registered.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state  <= S_IDLE;
            r_rtype  <= RT_NONE;
            r_bitcnt <= '0;
            r_tocnt  <= '0;
            r_txsh   <= '0;
            r_rx     <= '0;
            r_crc    <= '0;
            ocmd     <= 1'b1;
            ocmd_oe  <= 1'b0;
            odone    <= 1'b0;
            oresp    <= '0;
            otimeout <= 1'b0;
            ocrc_err <= 1'b0;
            obusy    <= 1'b0;
        end else begin
            odone <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (istart) begin
                        r_rtype  <= decode(iindex);
                        ocmd     <= w_frame[47];
                        ocmd_oe  <= 1'b1;
                        r_txsh   <= w_frame[46:0];
                        r_bitcnt <= '0;
                        otimeout <= 1'b0;
                        ocrc_err <= 1'b0;
                        obusy    <= 1'b1;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_bitcnt == 8'd47) begin
                        ocmd     <= 1'b1;
                        ocmd_oe  <= 1'b0;
                        r_bitcnt <= '0;
                        r_tocnt  <= '0;
                        r_state  <= (r_rtype == RT_NONE) ? S_GAP : S_WAIT;
                    end else begin
                        ocmd     <= r_txsh[46];
                        r_txsh   <= {r_txsh[45:0], 1'b1};
                        r_bitcnt <= r_bitcnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (!icmd) begin
                        r_crc    <= '0;
                        r_bitcnt <= (r_rtype == RT_R2) ? 8'd135 : 8'd47;
                        r_state  <= S_RECV;
                    end else if (r_tocnt == TW'(NCR_MAX - 1)) begin
                        otimeout <= 1'b1;
                        oresp    <= '0;
                        r_bitcnt <= '0;
                        r_state  <= S_GAP;
                    end else begin
                        r_tocnt <= r_tocnt + TW'(1);
                    end
                end
                S_RECV: begin
                    r_rx <= w_rx[82:0];
                    if (w_crc_on) begin
                        r_crc <= crc7_step(r_crc, icmd);
                    end
                    if (r_bitcnt == 8'd1) begin
                        oresp    <= (r_rtype == RT_R2) ? w_rx[83:8]
                                                       : {44'd0, w_rx[39:8]};
                        ocrc_err <= w_err;
                        r_bitcnt <= '0;
                        r_state  <= S_GAP;
                    end else begin
                        r_bitcnt <= r_bitcnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_bitcnt == 8'(NRC_GAP - 1)) begin
                        odone   <= 1'b1;
                        obusy   <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_bitcnt <= r_bitcnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd.sv
// tb_sd_cmd: directed bench for sd_cmd with a simple card model.
// Expected frames are hand constants or built by a reference CRC7 division.
module tb_sd_cmd;
    logic        iclk;
    logic        irst_n;
    logic        istart;
    logic [5:0]  iindex;
    logic [31:0] iarg;
    logic        icmd;
    logic        ocmd;
    logic        ocmd_oe;
    logic        odone;
    logic [75:0] oresp;
    logic        otimeout;
    logic        ocrc_err;
    logic        obusy;

    int n_cmp = 0;
    int n_err = 0;

    sd_cmd #(.NCR_MAX(64), .NRC_GAP(8)) dut (
        .iclk     (iclk),
        .irst_n   (irst_n),
        .istart   (istart),
        .iindex   (iindex),
        .iarg     (iarg),
        .icmd     (icmd),
        .ocmd     (ocmd),
        .ocmd_oe  (ocmd_oe),
        .odone    (odone),
        .oresp    (oresp),
        .otimeout (otimeout),
        .ocrc_err (ocrc_err),
        .obusy    (obusy)
    );

    // Free-running card clock.
    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Hard stop in case the run wedges somewhere unexpected.
    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [75:0] obs,
                       input logic [75:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CRC7 by polynomial long division, x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [119:0] d);
        logic [126:0] r;
        r = {d, 7'd0};
        for (int i = 126; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] r48(input logic [5:0] idx,
                                        input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b00, idx, arg};
        return {h, crc7_ref({80'd0, h}), 1'b1};
    endfunction

    // One full transaction; starts and ends on a falling edge so that
    // consecutive calls issue istart in the cycle right after odone.
    task automatic run_cmd(
        input  logic [5:0]   idx,
        input  logic [31:0]  arg,
        input  logic [135:0] rsp,
        input  int           rlen,
        input  int           dly,
        input  bit           poke,
        output logic [47:0]  txf,
        output int           oecnt,
        output int           gapcnt,
        output logic         busy_done,
        output logic         done_next
    );
        int guard;
        istart = 1'b1;
        iindex = idx;
        iarg   = arg;
        @(negedge iclk);
        istart = 1'b0;
        txf    = '0;
        oecnt  = 0;
        guard  = 0;
        while (ocmd_oe === 1'b1 && guard < 100) begin
            txf = {txf[46:0], ocmd};
            oecnt++;
            guard++;
            if (poke && oecnt == 10) begin
                istart = 1'b1;
                iindex = 6'd17;
                iarg   = 32'hFFFF_FFFF;
            end else begin
                istart = 1'b0;
            end
            @(negedge iclk);
        end
        istart = 1'b0;
        if (rlen > 0) begin
            repeat (dly) @(negedge iclk);
            for (int i = rlen - 1; i >= 0; i--) begin
                icmd = rsp[i];
                @(negedge iclk);
            end
            icmd = 1'b1;
        end
        gapcnt = 0;
        guard  = 0;
        while (odone !== 1'b1 && guard < 300) begin
            gapcnt++;
            guard++;
            @(negedge iclk);
        end
        busy_done = obusy;
        @(negedge iclk);
        done_next = odone;
    endtask

    logic [47:0]  txf;
    logic [47:0]  f;
    logic [135:0] rsp;
    logic [127:0] csd;
    int           oec;
    int           gap;
    logic         bd;
    logic         dn;

    initial begin
        irst_n = 1'b0;
        istart = 1'b0;
        iindex = '0;
        iarg   = '0;
        icmd   = 1'b1;
        repeat (3) @(negedge iclk);
        chk("rst_ocmd", 76'(ocmd), 76'd1);
        chk("rst_oe", 76'(ocmd_oe), 76'd0);
        chk("rst_done", 76'(odone), 76'd0);
        chk("rst_resp", oresp, 76'd0);
        chk("rst_to", 76'(otimeout), 76'd0);
        chk("rst_crc", 76'(ocrc_err), 76'd0);
        chk("rst_busy", 76'(obusy), 76'd0);
        irst_n = 1'b1;
        @(negedge iclk);

        // CMD55 with an R1 answer
        f = r48(6'd55, 32'h0000_0120);
        run_cmd(6'd55, 32'h0, {88'd0, f}, 48, 3, 1'b0,
                txf, oec, gap, bd, dn);
        chk("cmd55_frame", 76'(txf), 76'h77_0000_0000_65);
        chk("cmd55_oe_len", 76'(oec), 76'd48);
        chk("cmd55_resp", oresp, 76'h120);
        chk("cmd55_crc", 76'(ocrc_err), 76'd0);
        chk("cmd55_gap", 76'(gap), 76'd8);
        chk("cmd55_busy_done", 76'(bd), 76'd0);
        chk("cmd55_pulse", 76'(dn), 76'd0);

        // CMD8 with R7 answer 10 cycles after the end bit
        run_cmd(6'd8, 32'h0000_01AA, {88'd0, 48'h08_0000_01AA_13}, 48, 10,
                1'b0, txf, oec, gap, bd, dn);
        chk("cmd8_frame", 76'(txf), 76'h48_0000_01AA_87);
        chk("cmd8_resp", oresp, 76'h1AA);
        chk("cmd8_crc", 76'(ocrc_err), 76'd0);
        chk("cmd8_to", 76'(otimeout), 76'd0);
        chk("cmd8_gap", 76'(gap), 76'd8);

        // CMD9 with an R2 CSD
        csd = '0;
        csd[103:96] = 8'h32;
        csd[95:84]  = 12'h5B5;
        csd[83:80]  = 4'd9;
        csd[73:62]  = 12'hFFF;
        csd[49:47]  = 3'd7;
        rsp = {2'b00, 6'h3F, csd[127:8], crc7_ref(csd[127:8]), 1'b1};
        run_cmd(6'd9, 32'h0001_0000, rsp, 136, 5, 1'b0,
                txf, oec, gap, bd, dn);
        chk("cmd9_bl_len", 76'(oresp[75:72]), 76'd9);
        chk("cmd9_c_size", 76'(oresp[65:54]), 76'hFFF);
        chk("cmd9_c_mult", 76'(oresp[41:39]), 76'd7);
        chk("cmd9_resp", oresp, rsp[83:8]);
        chk("cmd9_crc", 76'(ocrc_err), 76'd0);
        chk("cmd9_gap", 76'(gap), 76'd8);

        // ACMD41 with R3 (CRC field all ones)
        run_cmd(6'd41, 32'h40FF_8000, {88'd0, 48'h3F_80FF_8000_FF}, 48, 2,
                1'b0, txf, oec, gap, bd, dn);
        chk("acmd41_crc", 76'(ocrc_err), 76'd0);
        chk("acmd41_bit31", 76'(oresp[31]), 76'd1);
        chk("acmd41_resp", oresp, 76'h80FF_8000);

        // CMD8 with a corrupted CRC bit
        run_cmd(6'd8, 32'h0000_01AA, {88'd0, 48'h08_0000_01AA_1B}, 48, 4,
                1'b0, txf, oec, gap, bd, dn);
        chk("badcrc_err", 76'(ocrc_err), 76'd1);
        chk("badcrc_resp", oresp, 76'h1AA);
        chk("badcrc_to", 76'(otimeout), 76'd0);

        // CMD17 with end bit 0
        f = r48(6'd17, 32'h0000_0900);
        f[0] = 1'b0;
        run_cmd(6'd17, 32'h0, {88'd0, f}, 48, 1, 1'b0,
                txf, oec, gap, bd, dn);
        chk("endbit_err", 76'(ocrc_err), 76'd1);
        chk("endbit_resp", oresp, 76'h900);

        // CMD13 with no answer
        run_cmd(6'd13, 32'h0001_0000, '0, 0, 0, 1'b0,
                txf, oec, gap, bd, dn);
        chk("cmd13_to", 76'(otimeout), 76'd1);
        chk("cmd13_resp", oresp, 76'd0);
        chk("cmd13_crc", 76'(ocrc_err), 76'd0);
        chk("cmd13_wait_gap", 76'(gap), 76'd72);
        chk("cmd13_busy_done", 76'(bd), 76'd0);
        chk("cmd13_pulse", 76'(dn), 76'd0);

        // CMD15, no response phase at all
        run_cmd(6'd15, 32'h0001_0000, '0, 0, 0, 1'b0,
                txf, oec, gap, bd, dn);
        chk("cmd15_oe_len", 76'(oec), 76'd48);
        chk("cmd15_gap", 76'(gap), 76'd8);
        chk("cmd15_to", 76'(otimeout), 76'd0);

        // istart pulsed mid-SEND is ignored
        f = r48(6'd55, 32'h0000_0120);
        run_cmd(6'd55, 32'h0, {88'd0, f}, 48, 6, 1'b1,
                txf, oec, gap, bd, dn);
        chk("poke_frame", 76'(txf), 76'h77_0000_0000_65);
        chk("poke_oe_len", 76'(oec), 76'd48);
        chk("poke_resp", oresp, 76'h120);

        // Reset in the middle of SEND
        istart = 1'b1;
        iindex = 6'd8;
        iarg   = 32'h0000_01AA;
        @(negedge iclk);
        istart = 1'b0;
        repeat (5) @(negedge iclk);
        chk("midrst_oe_before", 76'(ocmd_oe), 76'd1);
        chk("midrst_busy_before", 76'(obusy), 76'd1);
        irst_n = 1'b0;
        #1;
        chk("midrst_oe", 76'(ocmd_oe), 76'd0);
        chk("midrst_ocmd", 76'(ocmd), 76'd1);
        chk("midrst_busy", 76'(obusy), 76'd0);
        @(negedge iclk);
        irst_n = 1'b1;
        @(negedge iclk);
        run_cmd(6'd0, 32'h0, '0, 0, 0, 1'b0,
                txf, oec, gap, bd, dn);
        chk("cmd0_frame", 76'(txf), 76'h40_0000_0000_95);
        chk("cmd0_oe_len", 76'(oec), 76'd48);
        chk("cmd0_gap", 76'(gap), 76'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sd_cmd.md
Name: sd_cmd

Overview:
- CMD-line engine directly downstream of the SD bus controller FSM.
- Takes a start pulse, command index and argument; serialises the 48-bit command frame with CRC7 onto the CMD line; captures the card's response and CRC-checks it.
- Returns the response payload and a one-cycle done pulse, which the FSM consumes as icmd_done / iresp.
- Runs entirely in the SD card clock domain. One CMD bit per iclk cycle.

Parameters:
- NCR_MAX, 64, max cycles from command end bit to response start bit before timeout.
- NRC_GAP, 8, idle cycles inserted after the response (or after the command, if no response) before done.

Ports:
- iclk  in  1  SD card clock
- irst_n  in  1  asynchronous active-low reset
- istart  in  1  one-cycle start pulse; sampled only in IDLE
- iindex  in  6  command index
- iarg  in  32  command argument
- icmd  in  1  CMD line input (pad sampled)
- ocmd  out  1  CMD line output value
- ocmd_oe  out  1  CMD output enable (1 = drive)
- odone  out  1  one-cycle pulse when transaction completes (success or error)
- oresp  out  76  response payload
- otimeout  out  1  sticky per transaction: no start bit within NCR_MAX
- ocrc_err  out  1  sticky per transaction: CRC7 or end-bit mismatch
- obusy  out  1  high from accepted istart until odone

Behaviour:
- Reset (async, irst_n=0) values:
  - state=IDLE; ocmd=1, ocmd_oe=0, odone=0, oresp=0, otimeout=0, ocrc_err=0, obusy=0.
  - Reset mid-transaction aborts immediately and releases the line.
- Response type is decoded from iindex, latched at start:
  - none: 0, 15
  - R2 (136-bit): 2, 9
  - R3 (no CRC check): 41
  - R1/R1b/R6/R7 (48-bit): all others
  - R1b busy is not tracked here.
- IDLE: on istart, latch iindex and iarg, clear otimeout/ocrc_err, set obusy, go to SEND. istart outside IDLE is ignored.
- SEND, 48 cycles, ocmd_oe=1. Frame MSB first:
  - start bit 0, transmission bit 1, index[5:0], arg[31:0]
  - CRC7 over those first 40 bits: polynomial x^7+x^3+1, init 0
  - end bit 1
  - After the last bit, drop ocmd_oe with ocmd=1. No-response type goes to GAP; otherwise go to WAIT.
- WAIT:
  - Cycle counter starts at 0 in the first cycle after the end bit.
  - icmd==0 means the start bit was seen; go to RECV.
  - If the counter reaches NCR_MAX without a start bit: set otimeout, oresp=0, go to GAP.
- RECV: shift icmd in, 47 bits remaining (48-bit type) or 135 remaining (R2).
  - 48-bit types:
    - oresp[31:0] = frame bits 39:8; oresp[75:32] = 0.
    - Check the transmission bit is 0.
    - CRC7 is computed over frame bits 47:8 and compared with bits 7:1. Skipped for R3.
    - Check the end bit is 1.
  - R2:
    - oresp = register bits 83:8 (frame bits 83:8).
    - CRC7 is computed over register bits 127:8 only, excluding start, transmission and reserved bits, and compared with bits 7:1.
    - Check the end bit is 1.
  - Any mismatch sets ocrc_err; oresp still holds the received value.
  - oresp updates only on the last RECV cycle, so it never shows partial shifts.
- GAP: NRC_GAP cycles, line released, then DONE.
- DONE: odone=1 for exactly one cycle, obusy=0, back to IDLE.
  - oresp, otimeout and ocrc_err remain stable until the next accepted istart.
  - istart in the cycle right after odone is accepted. The FSM re-issues CMD13 this way.
- Counters: 8-bit bit counter; timeout counter wide enough for NCR_MAX; no wrap in either.
- Line contention: a card start bit seen during SEND is ignored.

Test Plan:
- CMD55 index 55, arg 0x00000000 → ocmd sequence 0x770000000065 (CRC7 0x32), ocmd_oe high for exactly 48 cycles.
- CMD8 arg 0x000001AA, card answers R7 0x08000001AA13 after 10 cycles → odone after response+8 cycles, oresp=0x000001AA, no errors.
- CMD9 with card-model R2 CSD (READ_BL_LEN=9, C_SIZE=0xFFF, C_SIZE_MULT=7) → oresp[75:72]=9, oresp[65:54]=0xFFF, oresp[41:39]=7, ocrc_err=0.
- ACMD41, card returns R3 with CRC field 0x7F → ocrc_err=0, oresp[31]=1.
- Any 48-bit command with a corrupted response CRC → ocrc_err=1.
- CMD13, icmd held 1 → otimeout=1 after 64 wait cycles, oresp=0, odone pulses once.
- Corner cases:
  - CMD15 → no RECV, odone 48+8 cycles after start.
  - irst_n low mid-SEND → ocmd_oe=0 immediately, next istart works.
  - istart during SEND → ignored.
